tick_seq_ctrl: RTL and testbench

- Countdown sequencer built around a shared 1 Hz prescaler for the 50 MHz board clock.
- Loads a count from the switch inputs, starts and pauses the prescaler, and decrements once per prescaler tick. Pulses `done` when the count reaches zero.
- Sits between the switch/button debouncers and the display/LED state machine, which consume `count`, `tick` and `done`.

---
 rtl/tick_pkg.sv | 17 +
 rtl/tick_seq_ctrl_if.sv | 29 ++
 rtl/tick_prescaler.sv | 41 ++++
 rtl/tick_seq_ctrl.sv | 102 ++++++++++
 tb/tb_tick_seq_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tick_pkg.sv
// Shared definitions for the countdown sequencer.
//   tick_state_e : FSM state encoding, also exported on the state output
//   DIV_50MHZ    : prescaler divide ratio giving a 1 Hz tick from 50 MHz
//   PW_50MHZ     : prescaler width large enough to hold DIV_50MHZ-1
package tick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } tick_state_e;

    localparam int unsigned DIV_50MHZ = 50_000_000;
    localparam int unsigned PW_50MHZ  = 26;

endpackage

// File: rtl/tick_seq_ctrl_if.sv
// Control/status bundle between the debounced switch logic and the
// countdown sequencer.
//   start, hold, clear : level requests from the debouncers
//   load_val           : countdown start value
//   count, tick, busy, done, state : sequencer status for display/LEDs
// master = requester side, slave = sequencer side.
interface tick_seq_ctrl_if #(
    parameter int CW = 8
);
    logic          start;
    logic          hold;
    logic          clear;
    logic [CW-1:0] load_val;
    logic [CW-1:0] count;
    logic          tick;
    logic          busy;
    logic          done;
    logic [1:0]    state;

    modport master (
        output start, hold, clear, load_val,
        input  count, tick, busy, done, state
    );

    modport slave (
        input  start, hold, clear, load_val,
        output count, tick, busy, done, state
    );
endinterface

// File: rtl/tick_prescaler.sv
// Free-running modulo-DIV prescaler with synchronous clear and enable.
//   clk, reset : clock, synchronous active-high reset
//   en         : advance the phase counter
//   clr        : force phase back to 0 (wins over en)
//   tick_o     : high while enabled in the last cycle of a period
module tick_prescaler #(
    parameter int unsigned DIV = 4,
    parameter int unsigned PW  = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick_o
);

    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign tick_o = en && (pre_q == PRE_LAST);

endmodule

// File: rtl/tick_seq_ctrl.sv
// Countdown sequencer: loads a count, decrements it once per prescaler
// period while running, pulses done when it reaches zero.
//   clk, reset : clock, synchronous active-high reset
//   bus        : tick_seq_ctrl_if slave (requests in, status out)
//
// state | meaning
// IDLE  | waiting for start, count and prescaler at 0
// RUN   | prescaler advancing, count decrements on each tick
// PAUSE | hold asserted, prescaler phase and count frozen
// DONE  | one-cycle done pulse, then back to IDLE
module tick_seq_ctrl
    import tick_pkg::*;
#(
    parameter int unsigned DIV = DIV_50MHZ,
    parameter int unsigned PW  = PW_50MHZ,
    parameter int unsigned CW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    tick_seq_ctrl_if.slave   bus
);

    tick_state_e   state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          pre_en;
    logic          pre_clr;
    logic          tick;

    assign pre_en  = (state_q == ST_RUN);
    // Phase restarts at every load, after every completion, and on abort.
    assign pre_clr = bus.clear
                   | ((state_q == ST_IDLE) && bus.start)
                   | (state_q == ST_DONE);

    tick_prescaler #(
        .DIV (DIV),
        .PW  (PW)
    ) u_pre (
        .clk    (clk),
        .reset  (reset),
        .en     (pre_en),
        .clr    (pre_clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (bus.clear) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        count_d = bus.load_val;
                        state_d = (bus.load_val != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        count_d = count_q - CW'(1);
                    end
                    // A hold coinciding with a tick still takes the decrement.
                    if (tick && (count_q == CW'(1))) begin
                        state_d = ST_DONE;
                    end else if (bus.hold) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (!bus.hold) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tick  = tick;
    assign bus.busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.state = state_q;

endmodule

// File: tb/tb_tick_seq_ctrl.sv
module tb_tick_seq_ctrl;

    localparam int DIV = 4;
    localparam int PW  = 3;
    localparam int CW  = 8;

    logic clk = 1'b0;
    logic reset;

    tick_seq_ctrl_if #(.CW(CW)) bus();

    tick_seq_ctrl #(.DIV(DIV), .PW(PW), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode (0 idle, 1 run, 2 pause, 3 done), the loaded
    // value and the number of RUN cycles elapsed since the load. Tick and
    // remaining count follow arithmetically from those.
    int m_mode = 0;
    int m_load = 0;
    int m_run  = 0;

    wire [12:0] got_vec = {bus.state, bus.count, bus.tick, bus.busy, bus.done};

    function automatic logic [12:0] exp_vec();
        logic       t, b, d;
        logic [7:0] c;
        t = (m_mode == 1) && ((m_run % DIV) == DIV - 1);
        b = (m_mode == 1) || (m_mode == 2);
        d = (m_mode == 3);
        c = b ? 8'(m_load - m_run / DIV) : 8'd0;
        return {2'(m_mode), c, t, b, d};
    endfunction

    task automatic model_step();
        if (reset || bus.clear) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (bus.start) begin
                    m_load = int'(bus.load_val);
                    m_run  = 0;
                    m_mode = (m_load != 0) ? 1 : 3;
                end
                1: begin
                    if (((m_run % DIV) == DIV - 1) && (m_load - m_run / DIV == 1)) begin
                        m_mode = 3;
                    end else begin
                        m_run++;
                        if (bus.hold) m_mode = 2;
                    end
                end
                2: if (!bus.hold) m_mode = 1;
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic h,
                         input logic cl, input logic [7:0] lv);
        reset        = r;
        bus.start    = st;
        bus.hold     = h;
        bus.clear    = cl;
        bus.load_val = lv;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'd9);
        advance();
        advance();
        n_cmp++;
        if (got_vec !== 13'd0) begin
            n_err++;
            $display("FAIL reset_state got=%h exp=%h", got_vec, 13'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        advance();
        n_cmp++;
        if (got_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_idle got=%h exp=%h", got_vec, exp_vec());
        end
    endtask

    task automatic test_basic();
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, c == 0, 1'b0, 1'b0, 8'd3);
            n_cmp++;
            if (got_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL basic_model c=%0d got=%h exp=%h", c, got_vec, exp_vec());
            end
            n_cmp++;
            if (bus.tick !== (c == 4 || c == 8 || c == 12)) begin
                n_err++;
                $display("FAIL basic_tick c=%0d got=%b", c, bus.tick);
            end
            n_cmp++;
            if (bus.done !== (c == 13)) begin
                n_err++;
                $display("FAIL basic_done c=%0d got=%b", c, bus.done);
            end
            n_cmp++;
            if (bus.busy !== (c >= 1 && c <= 12)) begin
                n_err++;
                $display("FAIL basic_busy c=%0d got=%b", c, bus.busy);
            end
            if (c == 5 || c == 9 || c == 13) begin
                n_cmp++;
                if (bus.count !== 8'(3 - (c - 1) / 4)) begin
                    n_err++;
                    $display("FAIL basic_count c=%0d got=%0d exp=%0d", c, bus.count, 3 - (c - 1) / 4);
                end
            end
            advance();
        end
    endtask

    task automatic test_pause();
        for (int c = 0; c < 26; c++) begin
            drive(1'b0, c == 0, c >= 2 && c <= 6, 1'b0, 8'd3);
            n_cmp++;
            if (got_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL pause_model c=%0d got=%h exp=%h", c, got_vec, exp_vec());
            end
            n_cmp++;
            if ((bus.state == 2'd2) !== (c >= 3 && c <= 7)) begin
                n_err++;
                $display("FAIL pause_state c=%0d got=%0d", c, bus.state);
            end
            advance();
        end
    endtask

    task automatic test_tick_hold();
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, c == 0, c == 4, 1'b0, 8'd3);
            n_cmp++;
            if (got_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL tickhold_model c=%0d got=%h exp=%h", c, got_vec, exp_vec());
            end
            if (c == 5) begin
                n_cmp++;
                if (bus.count !== 8'd2 || bus.state !== 2'd2 || bus.tick !== 1'b0) begin
                    n_err++;
                    $display("FAIL tickhold_c5 got count=%0d state=%0d tick=%b exp 2/2/0",
                             bus.count, bus.state, bus.tick);
                end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, c == 0, 1'b0, 1'b0, 8'd0);
            n_cmp++;
            if (got_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL zero_model c=%0d got=%h exp=%h", c, got_vec, exp_vec());
            end
            n_cmp++;
            if (bus.done !== (c == 1) || bus.tick !== 1'b0) begin
                n_err++;
                $display("FAIL zero_done c=%0d got done=%b tick=%b", c, bus.done, bus.tick);
            end
            advance();
        end
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
            n_cmp++;
            if (got_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL b2b_model c=%0d got=%h exp=%h", c, got_vec, exp_vec());
            end
            n_cmp++;
            if (bus.done !== ((c % 2) == 1)) begin
                n_err++;
                $display("FAIL b2b_done c=%0d got=%b", c, bus.done);
            end
            advance();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        advance();
    endtask

    task automatic test_abort();
        for (int v = 0; v < 2; v++) begin
            for (int c = 0; c < 20; c++) begin
                drive(v == 1 && c == 6, c == 0 || c == 8, 1'b0,
                      v == 0 && c == 6, (c == 0) ? 8'd5 : 8'd2);
                n_cmp++;
                if (got_vec !== exp_vec()) begin
                    n_err++;
                    $display("FAIL abort%0d_model c=%0d got=%h exp=%h", v, c, got_vec, exp_vec());
                end
                if (c == 7) begin
                    n_cmp++;
                    if (bus.state !== 2'd0 || bus.count !== 8'd0 || bus.done !== 1'b0) begin
                        n_err++;
                        $display("FAIL abort%0d_idle got state=%0d count=%0d done=%b",
                                 v, bus.state, bus.count, bus.done);
                    end
                end
                if (c >= 8 && c <= 15) begin
                    n_cmp++;
                    if (bus.tick !== (c == 12)) begin
                        n_err++;
                        $display("FAIL abort%0d_phase c=%0d got tick=%b", v, c, bus.tick);
                    end
                end
                advance();
            end
        end
    endtask

    task automatic test_wrap();
        int done_n  = 0;
        int done_at = -1;
        for (int c = 0; c < 1030; c++) begin
            drive(1'b0, c == 0, 1'b0, 1'b0, 8'd255);
            n_cmp++;
            if (got_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL wrap_model c=%0d got=%h exp=%h", c, got_vec, exp_vec());
            end
            if (bus.done === 1'b1) begin
                done_n++;
                done_at = c;
            end
            advance();
        end
        n_cmp++;
        if (done_n != 1 || done_at != 1021) begin
            n_err++;
            $display("FAIL wrap_done got n=%0d at=%0d exp n=1 at=1021", done_n, done_at);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 99) == 0, ($urandom % 4) == 0,
                  ($urandom % 3) == 0, $urandom_range(0, 59) == 0,
                  8'($urandom_range(0, 6)));
            n_cmp++;
            if (got_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL random_model c=%0d got=%h exp=%h", c, got_vec, exp_vec());
            end
            advance();
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        test_reset();
        test_basic();
        test_pause();
        test_tick_hold();
        test_back_to_back();
        test_abort();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
